// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtraction sequencer driving one external full-subtractor cell.
// Operands are captured on an accepted start and fed to the cell LSB-first.
// The borrow is registered between bits, and the difference is assembled
// MSB-in so that after WIDTH bits it is already in its final position.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iBin,
    output logic             oCellA,
    output logic             oCellB,
    output logic             oCellC,
    input  logic             iCellDiff,
    input  logic             iCellBorrow,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oDiff,
    output logic             oBorrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_run;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_res_next;

    assign w_run      = (r_state == S_RUN);
    assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

    // New difference bit enters at the MSB; the truncating cast also covers WIDTH=1
    assign w_res_next = WIDTH'({iCellDiff, r_res} >> 1);

    // The cell sees live operand bits only while a subtraction is running
    assign oCellA = w_run & r_sa[0];
    assign oCellB = w_run & r_sb[0];
    assign oCellC = w_run & r_br;

    assign oBusy   = r_busy;
    assign oDone   = r_done;
    assign oDiff   = r_diff;
    assign oBorrow = r_borrow;

    // Sequencer: IDLE -> RUN (WIDTH bits) -> DONE (one cycle) -> IDLE
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (iStart) begin
                        r_sa    <= iA;
                        r_sb    <= iB;
                        r_br    <= iBin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_res <= w_res_next;
                    r_br  <= iCellBorrow;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last_bit) begin
                        // Result is published on the same edge that enters DONE,
                        // so oDiff/oBorrow are valid alongside the oDone pulse
                        r_diff   <= w_res_next;
                        r_borrow <= iCellBorrow;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // iStart is deliberately ignored here; a new job starts from IDLE
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
